mem_stage_pipe: RTL

//  Parametrised pipelined MEM stage plus MEM/WB register for the RV32I core.

---
 rtl/mem_stage_pipe.sv | 328 ++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/mem_stage_pipe.sv
// mem_stage_pipe: RV32I memory stage plus MEM/WB pipeline register.
// Sizes loads and stores, generates byte enables, and suppresses misaligned
// accesses. Memory is reached through a req/ready handshake. A miss holds the
// stage in WAIT until ready, or until the timeout aborts it with a bus error.
module mem_stage_pipe #(
   parameter int ADDR_W         = 32,
   parameter int REG_AW         = 5,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic              clk,
   input  logic              rst,
   // M-stage instruction
   input  logic              RegWriteM,
   input  logic              ResultSrcM,
   input  logic              MemReadM,
   input  logic              MemWriteM,
   input  logic [2:0]        Funct3M,
   input  logic [ADDR_W-1:0] ALUResultM,
   input  logic [31:0]       WriteDataM,
   input  logic [REG_AW-1:0] RdM,
   input  logic              FlushM,
   output logic              StallM,
   // memory port
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic [3:0]        mem_be,
   input  logic [31:0]       mem_rdata,
   input  logic              mem_ready,
   // W-stage outputs
   output logic              RegWriteW,
   output logic              ResultSrcW,
   output logic [ADDR_W-1:0] ALUResultW,
   output logic [31:0]       ReadDataW,
   output logic [REG_AW-1:0] RdW,
   output logic              MisalignW,
   output logic              BusErrW
);

   // Counter just wide enough to reach TIMEOUT_CYCLES; one bit when disabled.
   localparam int CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic {
      S_IDLE,
      S_WAIT
   } state_t;

   typedef enum logic [1:0] {
      SZ_B,
      SZ_H,
      SZ_W
   } size_t;

   // ------------------------------------------------------------------
   // Access sizing helpers
   // ------------------------------------------------------------------

   // Funct3[1:0] picks the size; reserved encodings fall back to a word.
   function automatic size_t size_of(input logic [1:0] f3_lo);
      case (f3_lo)
         2'b00:   return SZ_B;
         2'b01:   return SZ_H;
         default: return SZ_W;
      endcase
   endfunction

   function automatic logic is_misaligned(input size_t sz, input logic [1:0] lo);
      case (sz)
         SZ_H:    return lo[0];
         SZ_W:    return lo != 2'b00;
         default: return 1'b0;
      endcase
   endfunction

   function automatic logic [3:0] byte_enables(input size_t sz, input logic [1:0] lo);
      case (sz)
         SZ_B:    return 4'b0001 << lo;
         SZ_H:    return lo[1] ? 4'b1100 : 4'b0011;
         default: return 4'b1111;
      endcase
   endfunction

   // Store data is replicated across every lane so the byte enables alone
   // select what is written.
   function automatic logic [31:0] lane_data(input size_t sz, input logic [31:0] wd);
      case (sz)
         SZ_B:    return {4{wd[7:0]}};
         SZ_H:    return {2{wd[15:0]}};
         default: return wd;
      endcase
   endfunction

   // Pick the addressed byte/half out of the read word and extend it.
   function automatic logic [31:0] load_extend(input logic [2:0]  f3,
                                               input logic [1:0]  lo,
                                               input logic [31:0] word);
      logic [7:0]  b;
      logic [15:0] h;
      case (lo)
         2'b00:   b = word[7:0];
         2'b01:   b = word[15:8];
         2'b10:   b = word[23:16];
         default: b = word[31:24];
      endcase
      h = lo[1] ? word[31:16] : word[15:0];
      case (f3)
         3'b000:  return {{24{b[7]}}, b};
         3'b001:  return {{16{h[15]}}, h};
         3'b100:  return {24'd0, b};
         3'b101:  return {16'd0, h};
         default: return word;
      endcase
   endfunction

   // ------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------
   state_t              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;

   // Copy of the stalled instruction, held while WAIT owns the bus.
   logic [ADDR_W-1:0]   lat_addr_q, lat_addr_d;
   logic                lat_we_q, lat_we_d;
   logic [3:0]          lat_be_q, lat_be_d;
   logic [31:0]         lat_wdata_q, lat_wdata_d;
   logic [2:0]          lat_f3_q, lat_f3_d;
   logic                lat_rw_q, lat_rw_d;
   logic                lat_rs_q, lat_rs_d;
   logic                lat_mr_q, lat_mr_d;
   logic [REG_AW-1:0]   lat_rd_q, lat_rd_d;

   // MEM/WB register
   logic                w_rw_q, w_rw_d;
   logic                w_rs_q, w_rs_d;
   logic [ADDR_W-1:0]   w_alu_q, w_alu_d;
   logic [31:0]         w_rdata_q, w_rdata_d;
   logic [REG_AW-1:0]   w_rd_q, w_rd_d;
   logic                w_mis_q, w_mis_d;
   logic                w_berr_q, w_berr_d;

   // ------------------------------------------------------------------
   // Decode of the instruction currently on the M inputs
   // ------------------------------------------------------------------
   size_t       m_size;
   logic        m_access;
   logic        m_misalign;
   logic [3:0]  m_be;
   logic [31:0] m_wdata;
   logic        timeout_hit;

   assign m_size      = size_of(Funct3M[1:0]);
   assign m_access    = MemReadM | MemWriteM;
   assign m_misalign  = is_misaligned(m_size, ALUResultM[1:0]);
   assign m_be        = byte_enables(m_size, ALUResultM[1:0]);
   assign m_wdata     = lane_data(m_size, WriteDataM);
   assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_W'(TIMEOUT_CYCLES));

   // Next-state, memory port and W-register input selection
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      lat_addr_d  = lat_addr_q;
      lat_we_d    = lat_we_q;
      lat_be_d    = lat_be_q;
      lat_wdata_d = lat_wdata_q;
      lat_f3_d    = lat_f3_q;
      lat_rw_d    = lat_rw_q;
      lat_rs_d    = lat_rs_q;
      lat_mr_d    = lat_mr_q;
      lat_rd_d    = lat_rd_q;
      // A bubble unless something below completes an instruction.
      w_rw_d      = 1'b0;
      w_rs_d      = 1'b0;
      w_alu_d     = '0;
      w_rdata_d   = '0;
      w_rd_d      = '0;
      w_mis_d     = 1'b0;
      w_berr_d    = 1'b0;
      mem_req     = 1'b0;
      mem_we      = MemWriteM;
      mem_addr    = {ALUResultM[ADDR_W-1:2], 2'b00};
      mem_be      = m_be;
      mem_wdata   = m_wdata;
      StallM      = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (FlushM) begin
               // killed instruction: bubble
            end else if (!m_access) begin
               w_rw_d  = RegWriteM;
               w_rs_d  = ResultSrcM;
               w_alu_d = ALUResultM;
               w_rd_d  = RdM;
            end else if (m_misalign) begin
               // access suppressed; never writes rd
               w_rs_d  = ResultSrcM;
               w_alu_d = ALUResultM;
               w_rd_d  = RdM;
               w_mis_d = 1'b1;
            end else begin
               mem_req = 1'b1;
               if (mem_ready) begin
                  w_rw_d    = RegWriteM;
                  w_rs_d    = ResultSrcM;
                  w_alu_d   = ALUResultM;
                  w_rd_d    = RdM;
                  w_rdata_d = MemReadM ? load_extend(Funct3M, ALUResultM[1:0], mem_rdata) : 32'd0;
               end else begin
                  StallM      = 1'b1;
                  state_d     = S_WAIT;
                  cnt_d       = CNT_W'(1);
                  lat_addr_d  = ALUResultM;
                  lat_we_d    = MemWriteM;
                  lat_be_d    = m_be;
                  lat_wdata_d = m_wdata;
                  lat_f3_d    = Funct3M;
                  lat_rw_d    = RegWriteM;
                  lat_rs_d    = ResultSrcM;
                  lat_mr_d    = MemReadM;
                  lat_rd_d    = RdM;
               end
            end
         end

         S_WAIT: begin
            // The bus is driven from the latched copy; FlushM has no effect.
            mem_req   = 1'b1;
            mem_we    = lat_we_q;
            mem_addr  = {lat_addr_q[ADDR_W-1:2], 2'b00};
            mem_be    = lat_be_q;
            mem_wdata = lat_wdata_q;
            if (mem_ready) begin
               w_rw_d    = lat_rw_q;
               w_rs_d    = lat_rs_q;
               w_alu_d   = lat_addr_q;
               w_rd_d    = lat_rd_q;
               w_rdata_d = lat_mr_q ? load_extend(lat_f3_q, lat_addr_q[1:0], mem_rdata) : 32'd0;
               state_d   = S_IDLE;
               cnt_d     = '0;
            end else if (timeout_hit) begin
               // give up: report the error and release the pipeline
               w_rs_d   = lat_rs_q;
               w_alu_d  = lat_addr_q;
               w_rd_d   = lat_rd_q;
               w_berr_d = 1'b1;
               state_d  = S_IDLE;
               cnt_d    = '0;
            end else begin
               StallM = 1'b1;
               if (cnt_q != '1) begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Nothing is requested or stalled while reset is held.
      if (rst) begin
         mem_req = 1'b0;
         StallM  = 1'b0;
      end
   end

   // FSM state, timeout counter and latched instruction
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         lat_addr_q  <= '0;
         lat_we_q    <= 1'b0;
         lat_be_q    <= '0;
         lat_wdata_q <= '0;
         lat_f3_q    <= '0;
         lat_rw_q    <= 1'b0;
         lat_rs_q    <= 1'b0;
         lat_mr_q    <= 1'b0;
         lat_rd_q    <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         lat_addr_q  <= lat_addr_d;
         lat_we_q    <= lat_we_d;
         lat_be_q    <= lat_be_d;
         lat_wdata_q <= lat_wdata_d;
         lat_f3_q    <= lat_f3_d;
         lat_rw_q    <= lat_rw_d;
         lat_rs_q    <= lat_rs_d;
         lat_mr_q    <= lat_mr_d;
         lat_rd_q    <= lat_rd_d;
      end
   end

   // MEM/WB register: loads every cycle (result or bubble)
   always_ff @(posedge clk) begin
      if (rst) begin
         w_rw_q    <= 1'b0;
         w_rs_q    <= 1'b0;
         w_alu_q   <= '0;
         w_rdata_q <= '0;
         w_rd_q    <= '0;
         w_mis_q   <= 1'b0;
         w_berr_q  <= 1'b0;
      end else begin
         w_rw_q    <= w_rw_d;
         w_rs_q    <= w_rs_d;
         w_alu_q   <= w_alu_d;
         w_rdata_q <= w_rdata_d;
         w_rd_q    <= w_rd_d;
         w_mis_q   <= w_mis_d;
         w_berr_q  <= w_berr_d;
      end
   end

   assign RegWriteW  = w_rw_q;
   assign ResultSrcW = w_rs_q;
   assign ALUResultW = w_alu_q;
   assign ReadDataW  = w_rdata_q;
   assign RdW        = w_rd_q;
   assign MisalignW  = w_mis_q;
   assign BusErrW    = w_berr_q;

endmodule
